// File: rtl/udp_tx_pkg.sv
// Shared types and constants for the UDP transmit framer.
package udp_tx_pkg;

  typedef enum logic [1:0] {IDLE, ARM, SEND, DRAIN} udp_tx_state_e;

  localparam int UDP_HDR_LEN    = 8;
  localparam int UDP_TX_LATENCY = 9;

  // Header byte idx of an 8-byte UDP header; the checksum field is always zero.
  function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                          input logic [15:0] src,
                                          input logic [15:0] dst,
                                          input logic [15:0] len);
    case (idx)
      3'd0:    return src[15:8];
      3'd1:    return src[7:0];
      3'd2:    return dst[15:8];
      3'd3:    return dst[7:0];
      3'd4:    return len[15:8];
      3'd5:    return len[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/udp_tx_framer_if.sv
// Application request/payload side and IP framed-byte side of the UDP framer.
// The master modport is the framer; the slave modport is its environment.
interface udp_tx_framer_if;
  logic        app_tx_data_request;
  logic        app_tx_ack;
  logic        udp_tx_ready;
  logic [7:0]  app_tx_data;
  logic        app_tx_data_valid;
  logic [15:0] udp_data_length;
  logic        ip_tx_ready;
  logic [7:0]  ip_tx_data;
  logic        ip_tx_valid;
  logic        ip_tx_sop;
  logic        ip_tx_eop;
  logic [15:0] ip_tx_length;

  modport master (
    input  app_tx_data_request, app_tx_data, app_tx_data_valid, udp_data_length, ip_tx_ready,
    output app_tx_ack, udp_tx_ready, ip_tx_data, ip_tx_valid, ip_tx_sop, ip_tx_eop, ip_tx_length
  );

  modport slave (
    output app_tx_data_request, app_tx_data, app_tx_data_valid, udp_data_length, ip_tx_ready,
    input  app_tx_ack, udp_tx_ready, ip_tx_data, ip_tx_valid, ip_tx_sop, ip_tx_eop, ip_tx_length
  );
endinterface

// File: rtl/udp_tx_delay_line.sv
// Fixed-depth shift register of {valid, last, data}; only the qualifiers are reset.
module udp_tx_delay_line #(
  parameter int DATA_W = 8,
  parameter int STAGES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic              in_last,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  output logic              out_last,
  output logic [DATA_W-1:0] out_data
);

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] last_p;
  logic [DATA_W-1:0] data_p [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p  <= '0;
      last_p <= '0;
    end else begin
      vld_p  <= {vld_p[STAGES-2:0], in_vld};
      last_p <= {last_p[STAGES-2:0], in_last};
    end
  end

  always_ff @(posedge clk) begin
    data_p[0] <= in_data;
    for (int i = 1; i < STAGES; i++) data_p[i] <= data_p[i-1];
  end

  assign out_vld  = vld_p[STAGES-1];
  assign out_last = last_p[STAGES-1];
  assign out_data = data_p[STAGES-1];

endmodule

// File: rtl/udp_tx_framer.sv
// UDP transmit framer: prepends an 8-byte header to a delayed payload stream.
// Optional packet/byte statistics are built when UDP_TX_STATS_EN is defined.
module udp_tx_framer
  import udp_tx_pkg::*;
#(
  parameter logic [15:0] SRC_PORT = 16'h1F90,
  parameter logic [15:0] DST_PORT = 16'h1F90
) (
  input  logic               app_tx_clk,
  input  logic               reset_n,
  udp_tx_framer_if.master    bus,
  output logic [31:0]        tx_pkt_cnt,
  output logic [31:0]        tx_byte_cnt
);

  udp_tx_state_e state_q, state_d;
  logic [15:0]   len_r;
  logic [15:0]   pcnt_q, pcnt_d;
  logic [2:0]    hcnt_q;
  logic          hdr_busy;
  logic          start, push, push_last, ack_d;
  logic          dl_vld, dl_last;
  logic [7:0]    dl_data;

  always_ff @(posedge app_tx_clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    ack_d     = 1'b0;
    start     = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.app_tx_data_request && bus.ip_tx_ready) begin
          ack_d   = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        // The first valid byte both starts the header and is payload byte 0.
        if (bus.app_tx_data_valid) begin
          start  = 1'b1;
          pcnt_d = '0;
          if (bus.udp_data_length == 16'd0) begin
            state_d = DRAIN;
          end else begin
            push      = 1'b1;
            push_last = (bus.udp_data_length == 16'd1);
            pcnt_d    = 16'd1;
            state_d   = push_last ? DRAIN : SEND;
          end
        end
      end
      SEND: begin
        if (bus.app_tx_data_valid && (pcnt_q < len_r)) begin
          push      = 1'b1;
          pcnt_d    = pcnt_q + 16'd1;
          push_last = (pcnt_d == len_r);
          if (push_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.ip_tx_eop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  udp_tx_delay_line #(
    .DATA_W (8),
    .STAGES (UDP_TX_LATENCY - 1)
  ) u_delay (
    .clk      (app_tx_clk),
    .rst_n    (reset_n),
    .in_vld   (push),
    .in_last  (push_last),
    .in_data  (bus.app_tx_data),
    .out_vld  (dl_vld),
    .out_last (dl_last),
    .out_data (dl_data)
  );

  // Output register: header bytes take priority while the header counter runs.
  always_ff @(posedge app_tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.app_tx_ack   <= 1'b0;
      bus.ip_tx_data   <= '0;
      bus.ip_tx_valid  <= 1'b0;
      bus.ip_tx_sop    <= 1'b0;
      bus.ip_tx_eop    <= 1'b0;
      bus.ip_tx_length <= '0;
      len_r            <= '0;
      pcnt_q           <= '0;
      hcnt_q           <= '0;
      hdr_busy         <= 1'b0;
    end else begin
      bus.app_tx_ack <= ack_d;
      pcnt_q         <= pcnt_d;
      if (start) begin
        len_r            <= bus.udp_data_length;
        bus.ip_tx_length <= bus.udp_data_length + 16'(UDP_HDR_LEN);
        bus.ip_tx_data   <= hdr_byte(3'd0, SRC_PORT, DST_PORT, 16'd0);
        bus.ip_tx_valid  <= 1'b1;
        bus.ip_tx_sop    <= 1'b1;
        bus.ip_tx_eop    <= 1'b0;
        hcnt_q           <= 3'd1;
        hdr_busy         <= 1'b1;
      end else if (hdr_busy) begin
        bus.ip_tx_data  <= hdr_byte(hcnt_q, SRC_PORT, DST_PORT, bus.ip_tx_length);
        bus.ip_tx_valid <= 1'b1;
        bus.ip_tx_sop   <= 1'b0;
        bus.ip_tx_eop   <= (hcnt_q == 3'd7) && (len_r == 16'd0);
        hcnt_q          <= hcnt_q + 3'd1;
        if (hcnt_q == 3'd7) hdr_busy <= 1'b0;
      end else begin
        bus.ip_tx_data  <= dl_vld ? dl_data : 8'h00;
        bus.ip_tx_valid <= dl_vld;
        bus.ip_tx_sop   <= 1'b0;
        bus.ip_tx_eop   <= dl_vld && dl_last;
      end
    end
  end

  assign bus.udp_tx_ready = reset_n && (state_q == IDLE) && bus.ip_tx_ready;

`ifdef UDP_TX_STATS_EN
  always_ff @(posedge app_tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_pkt_cnt  <= '0;
      tx_byte_cnt <= '0;
    end else if (bus.ip_tx_valid && bus.ip_tx_eop) begin
      tx_pkt_cnt  <= tx_pkt_cnt + 32'd1;
      tx_byte_cnt <= tx_byte_cnt + {16'h0000, bus.ip_tx_length};
    end
  end
`else
  assign tx_pkt_cnt  = '0;
  assign tx_byte_cnt = '0;
`endif

endmodule

// File: doc/udp_tx_framer.md
# udp_tx_framer

Downstream stage of the UDP loopback application path. Grants the application's send request with a one-cycle ack, and captures the payload length on the first valid byte. It then emits an 8-byte UDP header followed by the payload as a framed byte stream (sop/eop/length) to the IP transmit layer. The payload travels through a fixed 8-stage delay line, so the header is prepended without per-byte backpressure.

## Interface
- SRC_PORT, 16'h1F90, UDP source port placed in header bytes 0–1
- DST_PORT, 16'h1F90, UDP destination port placed in header bytes 2–3
- app_tx_clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- app_tx_data_request  in  1  application requests to send one packet
- app_tx_ack  out  1  one-cycle grant of the request
- udp_tx_ready  out  1  framer idle and IP layer ready
- app_tx_data  in  8  payload byte
- app_tx_data_valid  in  1  payload byte qualifier
- udp_data_length  in  16  payload length in bytes, sampled with the first valid byte
- ip_tx_ready  in  1  IP layer can accept a packet; packet-level grant only
- ip_tx_data  out  8  framed byte
- ip_tx_valid  out  1  byte qualifier
- ip_tx_sop  out  1  marks header byte 0
- ip_tx_eop  out  1  marks the last byte of the packet
- ip_tx_length  out  16  UDP length (payload+8), held stable from sop through eop
- tx_pkt_cnt  out  32  packets sent (see Configuration)
- tx_byte_cnt  out  32  UDP bytes sent (see Configuration)

## Operation
- States: IDLE, ARM, SEND, DRAIN.
- IDLE: udp_tx_ready = ip_tx_ready. If app_tx_data_request and ip_tx_ready are both high, pulse app_tx_ack for one cycle and go to ARM. If the request is high but ip_tx_ready is low, hold in IDLE with no ack.
- ARM: wait for app_tx_data_valid. On the first valid cycle:
  - latch len_r = udp_data_length
  - latch ip_tx_length = udp_data_length + 8, wrapping mod 2^16
  - start header emission, clear the payload counter, go to SEND
- Header bytes in order: SRC_PORT[15:8], SRC_PORT[7:0], DST_PORT[15:8], DST_PORT[7:0], LEN[15:8], LEN[7:0], 8'h00, 8'h00. Checksum is 0.
- SEND: each valid byte with pcnt < len_r enters the delay line and increments pcnt. Valid bytes with pcnt ≥ len_r are discarded. When pcnt reaches len_r, go to DRAIN.
- Gaps in app_tx_data_valid propagate through the delay line as gaps in ip_tx_valid. There is no timeout: SEND persists until len_r bytes have been accepted.
- len_r == 0: the packet is header only. eop is on header byte 7 and all incoming payload bytes are discarded; go directly to DRAIN.
- DRAIN: stay until the byte carrying eop has left the output register, then go to IDLE.
- udp_tx_ready is low in ARM, SEND and DRAIN.
- Reset mid-packet: the packet is abandoned, no eop is emitted, and the state returns to IDLE.

## Timing
- Reset values: every output is 0, state is IDLE.
- Ack asserts the cycle after request∧ip_tx_ready is sampled in IDLE. Ack lasts exactly 1 cycle.
- With the first valid byte at input cycle c0, header byte k appears at ip_tx_data in cycle c0+1+k (k = 0..7). ip_tx_sop is high with header byte 0.
- Payload byte i entering at input cycle t appears at output cycle t+9. With contiguous input, the payload follows the header with no gap.
- ip_tx_eop is high on the output cycle of payload byte len_r−1.
- IDLE is entered the cycle after eop. The next ack occurs no earlier than 2 cycles after eop.

## Configuration
- UDP_TX_STATS_EN defined:
  - tx_pkt_cnt increments by 1 at each eop.
  - tx_byte_cnt adds ip_tx_length at each eop.
  - Both counters are 32-bit, wrap at 2^32, and are cleared by reset.
- Not defined: both counters are tied to 0 and the counter logic is absent.

## Structure
- Shared package udp_tx_pkg holds:
  - the state enum (IDLE/ARM/SEND/DRAIN)
  - UDP_HDR_LEN = 8
  - UDP_TX_LATENCY = 9
- Sub-module udp_tx_delay_line: an 8-stage shift register of {valid, last, data}. The top level muxes its output against the header byte counter into the output register.

## Test plan
- Request with ip_tx_ready=1, then 4 contiguous payload bytes A0..A3 with length 4:
  - ack is 1 cycle
  - output is 1F 90 1F 90 00 0C 00 00 A0 A1 A2 A3
  - sop on the first byte, eop on A3, ip_tx_length = 12
- Request with ip_tx_ready=0 for 5 cycles, then ip_tx_ready=1: no ack during those 5 cycles; ack on the cycle after ready rises.
- Length 3 with a 2-cycle valid gap after byte 1: the output shows the same 2-cycle ip_tx_valid gap; eop on byte 2.
- Length 2 with 4 valid bytes sent: only bytes 0–1 are output; the extra 2 are discarded and the state returns to IDLE.
- Length 0: the packet is the 8 header bytes with LEN = 0008 and eop on header byte 7.
- reset_n low during payload byte 5 of a 10-byte packet: all outputs go to 0 immediately with no eop. The next request is acked normally. With UDP_TX_STATS_EN, tx_pkt_cnt is 0.
